axil_master_engine: RTL

Synthesizable, parametrised AXI4-Lite master that turns single register-access commands into protocol-correct AXI4-Lite read or write transactions. It replaces the testbench-only register tasks with an RTL engine, and is intended for the NIC shell's register-access path and for self-checking benches. It handles independent AW/W acceptance, byte strobes, response codes and an optional per-transaction timeout. One transaction is in flight at a time.

---
 rtl/axil_pkg.sv | 18 +
 rtl/axil_master_engine.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/axil_pkg.sv
// Shared types and constants for the AXI4-Lite register-access master.
package axil_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_B,
    RD_AR,
    RD_R,
    RSP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axil_master_engine.sv
// Single-outstanding AXI4-Lite master: one register command in, one AXI read or
// write transaction out, one response back. Every output is a flop.
module axil_master_engine
  import axil_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_wstrb,

  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_timeout,

  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [ADDR_W-1:0]     m_awaddr,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wstrb,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  input  logic [1:0]            m_bresp,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  output logic [ADDR_W-1:0]     m_araddr,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  input  logic [DATA_W-1:0]     m_rdata,
  input  logic [1:0]            m_rresp
);

  localparam int            TW     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TMO    = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMAX   = '1;
  localparam bit            TMO_EN = (TIMEOUT_CYCLES > 0);

  state_t              state, state_nxt;
  logic [TW-1:0]       timer, timer_nxt, timer_inc;
  logic                aw_done, aw_done_nxt, w_done, w_done_nxt;
  logic                expire, abort;
  logic                aw_hs, w_hs, b_hs, ar_hs, r_hs;

  logic                cmd_ready_nxt, rsp_valid_nxt, rsp_timeout_nxt;
  logic [DATA_W-1:0]   rsp_rdata_nxt, wdata_nxt;
  logic [1:0]          rsp_resp_nxt;
  logic                awvalid_nxt, wvalid_nxt, bready_nxt, arvalid_nxt, rready_nxt;
  logic [ADDR_W-1:0]   awaddr_nxt, araddr_nxt;
  logic [DATA_W/8-1:0] wstrb_nxt;

  assign aw_hs = m_awvalid & m_awready;
  assign w_hs  = m_wvalid  & m_wready;
  assign b_hs  = m_bvalid  & m_bready;
  assign ar_hs = m_arvalid & m_arready;
  assign r_hs  = m_rvalid  & m_rready;

  // Saturating timer; expiry is the cycle whose increment reaches the limit.
  assign timer_inc = (timer == TMAX) ? timer : timer + TW'(1);
  assign expire    = TMO_EN && (timer_inc == TMO);

  always_comb begin
    state_nxt       = state;
    timer_nxt       = timer;
    aw_done_nxt     = aw_done;
    w_done_nxt      = w_done;
    abort           = 1'b0;
    cmd_ready_nxt   = cmd_ready;
    rsp_valid_nxt   = rsp_valid;
    rsp_rdata_nxt   = rsp_rdata;
    rsp_resp_nxt    = rsp_resp;
    rsp_timeout_nxt = rsp_timeout;
    awvalid_nxt     = m_awvalid;
    wvalid_nxt      = m_wvalid;
    bready_nxt      = m_bready;
    arvalid_nxt     = m_arvalid;
    rready_nxt      = m_rready;
    awaddr_nxt      = m_awaddr;
    araddr_nxt      = m_araddr;
    wdata_nxt       = m_wdata;
    wstrb_nxt       = m_wstrb;

    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          cmd_ready_nxt = 1'b0;
          timer_nxt     = '0;
          aw_done_nxt   = 1'b0;
          w_done_nxt    = 1'b0;
          if (cmd_write) begin
            state_nxt   = WR;
            awaddr_nxt  = cmd_addr;
            wdata_nxt   = cmd_wdata;
            wstrb_nxt   = cmd_wstrb;
            awvalid_nxt = 1'b1;
            wvalid_nxt  = 1'b1;
          end else begin
            state_nxt   = RD_AR;
            araddr_nxt  = cmd_addr;
            arvalid_nxt = 1'b1;
          end
        end
      end
      WR: begin
        timer_nxt = timer_inc;
        if ((aw_done || aw_hs) && (w_done || w_hs)) begin
          state_nxt   = WR_B;
          awvalid_nxt = 1'b0;
          wvalid_nxt  = 1'b0;
          bready_nxt  = 1'b1;
        end else if (expire) begin
          abort = 1'b1;
        end else begin
          aw_done_nxt = aw_done | aw_hs;
          w_done_nxt  = w_done  | w_hs;
          awvalid_nxt = ~(aw_done | aw_hs);
          wvalid_nxt  = ~(w_done  | w_hs);
        end
      end
      WR_B: begin
        timer_nxt = timer_inc;
        if (b_hs) begin
          state_nxt       = RSP;
          bready_nxt      = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_resp_nxt    = m_bresp;
          rsp_rdata_nxt   = '0;
          rsp_timeout_nxt = 1'b0;
        end else if (expire) begin
          abort = 1'b1;
        end
      end
      RD_AR: begin
        timer_nxt = timer_inc;
        if (ar_hs) begin
          state_nxt   = RD_R;
          arvalid_nxt = 1'b0;
          rready_nxt  = 1'b1;
        end else if (expire) begin
          abort = 1'b1;
        end
      end
      RD_R: begin
        timer_nxt = timer_inc;
        if (r_hs) begin
          state_nxt       = RSP;
          rready_nxt      = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_resp_nxt    = m_rresp;
          rsp_rdata_nxt   = m_rdata;
          rsp_timeout_nxt = 1'b0;
        end else if (expire) begin
          abort = 1'b1;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          state_nxt     = IDLE;
          rsp_valid_nxt = 1'b0;
          cmd_ready_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A timed-out transaction is abandoned; any late slave reply is ignored.
    if (abort) begin
      state_nxt       = RSP;
      awvalid_nxt     = 1'b0;
      wvalid_nxt      = 1'b0;
      bready_nxt      = 1'b0;
      arvalid_nxt     = 1'b0;
      rready_nxt      = 1'b0;
      rsp_valid_nxt   = 1'b1;
      rsp_resp_nxt    = RESP_SLVERR;
      rsp_rdata_nxt   = '0;
      rsp_timeout_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      timer       <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_resp    <= RESP_OKAY;
      rsp_timeout <= 1'b0;
      m_awvalid   <= 1'b0;
      m_wvalid    <= 1'b0;
      m_bready    <= 1'b0;
      m_arvalid   <= 1'b0;
      m_rready    <= 1'b0;
      m_awaddr    <= '0;
      m_araddr    <= '0;
      m_wdata     <= '0;
      m_wstrb     <= '0;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      aw_done     <= aw_done_nxt;
      w_done      <= w_done_nxt;
      cmd_ready   <= cmd_ready_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_rdata   <= rsp_rdata_nxt;
      rsp_resp    <= rsp_resp_nxt;
      rsp_timeout <= rsp_timeout_nxt;
      m_awvalid   <= awvalid_nxt;
      m_wvalid    <= wvalid_nxt;
      m_bready    <= bready_nxt;
      m_arvalid   <= arvalid_nxt;
      m_rready    <= rready_nxt;
      m_awaddr    <= awaddr_nxt;
      m_araddr    <= araddr_nxt;
      m_wdata     <= wdata_nxt;
      m_wstrb     <= wstrb_nxt;
    end
  end

endmodule
